pixel_writer: RTL and testbench

- Consumes the 64-bit pixel stream produced by the line rasteriser.
- Buffers pixels in a small synchronous FIFO and clips them against the screen bounds.
- Converts each (x,y) into a framebuffer byte address and issues one 32-bit Avalon-MM write per pixel toward SDRAM.
- Drives pixel_fifo_full back to the rasteriser as its stall input.

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/pixel_writer_sync_fifo.sv | 62 ++++++
 rtl/pixel_writer.sv | 162 ++++++++++++++++
 tb/tb_pixel_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared pixel-stream field layout, writer FSM encoding and address helper.
// Rev 1.0
`default_nettype none

package gpu_pkg;

  localparam int PIX_X_MSB       = 63;
  localparam int PIX_Y_MSB       = 47;
  localparam int PIX_COL_MSB     = 31;
  localparam int BYTES_PER_PIXEL = 4;
  localparam int BPP_SHIFT       = $clog2(BYTES_PER_PIXEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } pw_state_e;

  // Byte offset of (x,y) in a linear framebuffer; wraps modulo 2^32.
  function automatic logic [31:0] pixel_offset(input logic [15:0] x,
                                               input logic [15:0] y,
                                               input int unsigned h_res);
    logic [31:0] lin;
    lin = ({16'd0, y} * 32'(h_res)) + {16'd0, x};
    return lin << BPP_SHIFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_writer_sync_fifo.sv
// sync_fifo: synchronous show-ahead FIFO; head word is visible on dout whenever non-empty.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_pop, do_push;

  // A push at full is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pixel_writer.sv
// pixel_writer: buffers rasterised pixels, clips to screen and issues one Avalon-MM write per pixel.
// Rev 1.0
`default_nettype none

module pixel_writer
  import gpu_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] pixel_data,
  input  logic        pixel_data_valid,
  output logic        pixel_fifo_full,
  input  logic        enable,
  input  logic [31:0] fb_base,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] clip_count,
  output logic [31:0] pixel_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [63:0]   fifo_dout;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_push, fifo_pop;
  logic [CW-1:0] count_d;

  pw_state_e   state_q, state_d;
  logic [15:0] px_x_q, px_x_d;
  logic [15:0] px_y_q, px_y_d;
  logic [31:0] px_col_q, px_col_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] clip_q, clip_d;
  logic [31:0] pcount_q, pcount_d;
  logic        full_q, full_d;
  logic        ovf_q, ovf_d;
  logic        out_of_range;

  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && enable;
  assign fifo_push = pixel_data_valid &&
                     ((fifo_count != CW'(FIFO_DEPTH)) || fifo_pop);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (pixel_data),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stall is registered from the post-edge occupancy so the upstream sees it one cycle early.
  always_comb begin
    count_d = fifo_count;
    if (fifo_push && !fifo_pop)      count_d = fifo_count + 1'b1;
    else if (fifo_pop && !fifo_push) count_d = fifo_count - 1'b1;
    full_d = (count_d >= CW'(FIFO_DEPTH - FULL_MARGIN));
    ovf_d  = ovf_q | (pixel_data_valid & ~fifo_push);
  end

  assign out_of_range = (px_x_q >= 16'(H_RES)) || (px_y_q >= 16'(V_RES));

  always_comb begin
    state_d  = state_q;
    px_x_d   = px_x_q;
    px_y_d   = px_y_q;
    px_col_d = px_col_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    clip_d   = clip_q;
    pcount_d = pcount_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          px_x_d   = fifo_dout[PIX_X_MSB -: 16];
          px_y_d   = fifo_dout[PIX_Y_MSB -: 16];
          px_col_d = fifo_dout[PIX_COL_MSB -: 32];
          state_d  = CALC;
        end
      end
      CALC: begin
        if (out_of_range) begin
          if (clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
          state_d = IDLE;
        end else begin
          addr_d  = fb_base + pixel_offset(px_x_q, px_y_q, H_RES);
          wdata_d = px_col_q;
          write_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          write_d  = 1'b0;
          pcount_d = pcount_q + 32'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      px_x_q   <= '0;
      px_y_q   <= '0;
      px_col_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      clip_q   <= '0;
      pcount_q <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_x_q   <= px_x_d;
      px_y_q   <= px_y_d;
      px_col_q <= px_col_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      clip_q   <= clip_d;
      pcount_q <= pcount_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pixel_fifo_full = full_q;
  assign avm_address     = addr_q;
  assign avm_write       = write_q;
  assign avm_writedata   = wdata_q;
  assign avm_byteenable  = 4'hF;
  assign busy            = !fifo_empty || (state_q != IDLE);
  assign overflow        = ovf_q;
  assign clip_count      = clip_q;
  assign pixel_count     = pcount_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: scoreboard bench for pixel_writer.
// Rev 1.0
`default_nettype none

module tb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] pixel_data;
  logic        pixel_data_valid;
  logic        pixel_fifo_full;
  logic        enable;
  logic [31:0] fb_base;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        busy;
  logic        overflow;
  logic [15:0] clip_count;
  logic [31:0] pixel_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic        prev_wr = 1'b0;
  logic [63:0] prev_ad = '0;

  pixel_writer dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .pixel_fifo_full  (pixel_fifo_full),
    .enable           (enable),
    .fb_base          (fb_base),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .busy             (busy),
    .overflow         (overflow),
    .clip_count       (clip_count),
    .pixel_count      (pixel_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one pixel for one cycle; in-range pixels that should be written go to the scoreboard.
  task automatic drive(input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] col, input bit expect_wr);
    logic [31:0] a;
    pixel_data_valid = 1'b1;
    pixel_data       = {x, y, col};
    if (expect_wr && x < 16'd640 && y < 16'd480) begin
      a = fb_base + ((32'(y) * 32'd640 + 32'(x)) << 2);
      sb.push_back({a, col});
    end
    tick();
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) tick();
    chk(tag, 64'(busy), 64'd0);
  endtask

  always @(negedge clock) begin
    if (reset_n && avm_write) begin
      if (prev_wr) chk("wr_stable", {avm_address, avm_writedata}, prev_ad);
      chk("byteenable", 64'(avm_byteenable), 64'hF);
      if (!avm_waitrequest) begin
        if (sb.size() == 0) chk("unexpected_wr", 64'd1, 64'd0);
        else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("wr_addr", 64'(avm_address), 64'(e[63:32]));
          chk("wr_data", 64'(avm_writedata), 64'(e[31:0]));
        end
      end
    end
    prev_wr = reset_n && avm_write && avm_waitrequest;
    prev_ad = {avm_address, avm_writedata};
  end

  initial begin
    int hi;
    reset_n = 1'b0; pixel_data = '0; pixel_data_valid = 1'b0;
    enable = 1'b1; fb_base = 32'h0010_0000; avm_waitrequest = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_write", 64'(avm_write), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_data", 64'(avm_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full", 64'(pixel_fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_clip", 64'(clip_count), 64'd0);
    chk("rst_pcnt", 64'(pixel_count), 64'd0);

    // Single pixel latency and address.
    drive(16'd10, 16'd2, 32'hFF00FF00, 1'b1);
    pixel_data_valid = 1'b0;
    chk("lat_c1", 64'(avm_write), 64'd0);
    tick();
    chk("lat_c2", 64'(avm_write), 64'd0);
    tick();
    chk("lat_c3", 64'(avm_write), 64'd1);
    chk("single_addr", 64'(avm_address), 64'h0010_1428);
    chk("single_data", 64'(avm_writedata), 64'hFF00FF00);
    tick();
    chk("single_done", 64'(avm_write), 64'd0);
    chk("single_pcnt", 64'(pixel_count), 64'd1);

    // Clipping on both axes.
    drive(16'd640, 16'd0, 32'h1111_1111, 1'b1);
    drive(16'd0, 16'd480, 32'h2222_2222, 1'b1);
    pixel_data_valid = 1'b0;
    wait_idle("clip_idle", 6);
    chk("clip_count", 64'(clip_count), 64'd2);
    chk("clip_pcnt", 64'(pixel_count), 64'd1);

    // Write stretched by 5 cycles of waitrequest.
    avm_waitrequest = 1'b1;
    fb_base = 32'h8000_0000;
    drive(16'd639, 16'd479, 32'hCAFE_0001, 1'b1);
    pixel_data_valid = 1'b0;
    for (int i = 0; i < 10 && !avm_write; i++) tick();
    chk("ws_started", 64'(avm_write), 64'd1);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (avm_write) hi++;
      avm_waitrequest = (k < 5);
      tick();
    end
    avm_waitrequest = 1'b0;
    chk("ws_high_cycles", 64'(hi), 64'd6);
    chk("ws_pcnt", 64'(pixel_count), 64'd2);

    // enable low holds queued pixels.
    enable = 1'b0;
    fb_base = 32'hFFFF_FF00;
    for (int i = 0; i < 3; i++) drive(16'(i * 7), 16'(i + 1), 32'hE000_0000 + 32'(i), 1'b1);
    pixel_data_valid = 1'b0;
    repeat (5) tick();
    chk("en_busy", 64'(busy), 64'd1);
    chk("en_nowr", 64'(pixel_count), 64'd2);
    enable = 1'b1;
    wait_idle("en_idle", 30);
    chk("en_pcnt", 64'(pixel_count), 64'd5);

    // Burst of 20 against a stalled slave.
    avm_waitrequest = 1'b1;
    fb_base = 32'h0020_0000;
    for (int k = 0; k < 20; k++) begin
      int mc;
      drive(16'($urandom_range(0, 639)), 16'($urandom_range(0, 479)),
            32'hB000_0000 + 32'(k), k <= 16);
      mc = (k == 0) ? 1 : ((k > 16) ? 16 : k);
      chk($sformatf("burst_full_%0d", k), 64'(pixel_fifo_full), 64'(mc >= 14));
      if (k == 16) chk("burst_ovf_pre", 64'(overflow), 64'd0);
      if (k == 17) chk("burst_ovf", 64'(overflow), 64'd1);
    end
    pixel_data_valid = 1'b0;
    avm_waitrequest = 1'b0;
    wait_idle("burst_idle", 200);
    chk("burst_pcnt", 64'(pixel_count), 64'd22);
    chk("burst_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a stalled write.
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 15; k++) drive(16'(k), 16'(k), 32'hD000_0000 + 32'(k), 1'b0);
    pixel_data_valid = 1'b0;
    chk("pre_rst_write", 64'(avm_write), 64'd1);
    chk("pre_rst_full", 64'(pixel_fifo_full), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_write", 64'(avm_write), 64'd0);
    chk("mid_rst_pcnt", 64'(pixel_count), 64'd0);
    chk("mid_rst_clip", 64'(clip_count), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_full", 64'(pixel_fifo_full), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    avm_waitrequest = 1'b0;
    repeat (4) tick();
    chk("post_rst_quiet", 64'(avm_write), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
